// File: rtl/mult_share_sched_if.sv
// rtl/mult_share_sched_if.sv - requester, multiplier and response signals of the shared-multiplier scheduler
interface mult_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 24
) ();
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*WIDTH-1:0] req_a_i;
  logic [NUM_REQ*WIDTH-1:0] req_b_i;
  logic                     mul_valid_o;
  logic [WIDTH-1:0]         mul_a_o;
  logic [WIDTH-1:0]         mul_b_o;
  logic                     mul_valid_i;
  logic [2*WIDTH-1:0]       mul_product_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [IW-1:0]            rsp_id_o;
  logic [2*WIDTH-1:0]       rsp_product_o;
  logic                     err_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, mul_valid_i, mul_product_i, rsp_ready_i,
    output req_ready_o, mul_valid_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o,
           rsp_product_o, err_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, mul_valid_i, mul_product_i, rsp_ready_i,
    input  req_ready_o, mul_valid_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o,
           rsp_product_o, err_o
  );
endinterface

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin scheduler sharing one pipelined multiplier among requesters
module mult_share_sched #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 24,
  parameter int MULT_LATENCY = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mult_share_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW:0]   NREQ  = (IW+1)'(NUM_REQ);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d, grant_idx;
  logic [IW:0]        pos;
  logic               grant_found, can_issue, hs;
  logic [NUM_REQ-1:0] ready;
  logic [CW-1:0]      credit_q, credit_d;

  logic               mul_valid_q;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;
  logic [IW-1:0]      issue_id_q;

  logic [MULT_LATENCY-1:0] tag_v_q;
  logic [IW-1:0]           tag_id_q [MULT_LATENCY];

  logic               ret_v_q, ret_tag_v_q;
  logic [IW-1:0]      ret_id_q;
  logic [PW-1:0]      ret_prod_q;

  logic [IW-1:0]      fifo_id_q   [FIFO_DEPTH];
  logic [PW-1:0]      fifo_prod_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q, fifo_cnt;
  logic               fifo_full, rsp_valid, rd_en, wr_req, wr_en, tag_drop, err_set;
  logic               err_q;

  // First valid requester at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    pos         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (pos >= NREQ) pos = pos - NREQ;
      if (!grant_found && bus.req_valid_i[pos[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = pos[IW-1:0];
      end
    end
  end

  assign can_issue = credit_q < DEPTH;
  assign ready     = (!rst_i && can_issue && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign hs        = |(bus.req_valid_i & ready);

  assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
  assign fifo_full = fifo_cnt == (AW+1)'(FIFO_DEPTH);
  assign rsp_valid = wr_ptr_q != rd_ptr_q;
  assign rd_en     = rsp_valid & bus.rsp_ready_i;
  assign wr_req    = ret_v_q & ret_tag_v_q;
  assign wr_en     = wr_req & (~fifo_full | rd_en);
  assign tag_drop  = ret_tag_v_q & ~ret_v_q;
  assign err_set   = (ret_v_q & ~ret_tag_v_q) | tag_drop | (wr_req & ~wr_en);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
    credit_d = credit_q + CW'(hs) - CW'(rd_en) - CW'(tag_drop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      credit_q    <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      issue_id_q  <= '0;
      tag_v_q     <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) tag_id_q[i] <= '0;
      ret_v_q     <= 1'b0;
      ret_tag_v_q <= 1'b0;
      ret_id_q    <= '0;
      ret_prod_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      mul_valid_q <= hs;
      if (hs) begin
        mul_a_q    <= WIDTH'(bus.req_a_i >> (int'(grant_idx) * WIDTH));
        mul_b_q    <= WIDTH'(bus.req_b_i >> (int'(grant_idx) * WIDTH));
        issue_id_q <= grant_idx;
      end
      tag_v_q[0]  <= mul_valid_q;
      tag_id_q[0] <= issue_id_q;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      // Product and tag are registered once more before the FIFO write.
      ret_v_q     <= bus.mul_valid_i;
      ret_tag_v_q <= tag_v_q[MULT_LATENCY-1];
      ret_id_q    <= tag_id_q[MULT_LATENCY-1];
      ret_prod_q  <= bus.mul_product_i;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      err_q <= err_q | err_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      fifo_id_q[wr_ptr_q[AW-1:0]]   <= ret_id_q;
      fifo_prod_q[wr_ptr_q[AW-1:0]] <= ret_prod_q;
    end
  end

  assign bus.req_ready_o   = ready;
  assign bus.mul_valid_o   = mul_valid_q;
  assign bus.mul_a_o       = mul_a_q;
  assign bus.mul_b_o       = mul_b_q;
  assign bus.rsp_valid_o   = rsp_valid;
  assign bus.rsp_id_o      = rsp_valid ? fifo_id_q[rd_ptr_q[AW-1:0]] : '0;
  assign bus.rsp_product_o = rsp_valid ? fifo_prod_q[rd_ptr_q[AW-1:0]] : '0;
  assign bus.err_o         = err_q;
endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - self-checking bench for mult_share_sched
module tb_mult_share_sched;
  localparam int NR = 4;
  localparam int W  = 24;
  localparam int L  = 8;
  localparam int D  = 16;
  localparam int PW = 2 * W;

  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [PW-1:0] p; } vec_t;
  typedef struct { int id; logic [PW-1:0] p; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inject = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  int   model_rr = 0;
  int   model_credit = 0;
  rsp_t expq[$];

  logic [L-1:0]  mp_v;
  logic [PW-1:0] mp_p [L];

  mult_share_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus();

  mult_share_sched #(.NUM_REQ(NR), .WIDTH(W), .MULT_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: L-stage pipe sharing the scheduler's reset.
  always @(posedge clk) begin
    if (rst) mp_v <= '0;
    else begin
      mp_v    <= {mp_v[L-2:0], bus.mul_valid_o};
      mp_p[0] <= PW'(bus.mul_a_o) * PW'(bus.mul_b_o);
      for (int i = 1; i < L; i++) mp_p[i] <= mp_p[i-1];
    end
  end
  assign bus.mul_valid_i   = mp_v[L-1] | inject;
  assign bus.mul_product_i = mp_p[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: check grant against the reference model, score responses, advance the model.
  task automatic cycle();
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] v;
    logic [PW-1:0] pa, pb;
    logic          rsp_hs;
    rsp_t          e;
    int            g;
    #1;
    v = bus.req_valid_i;
    exp_ready = '0;
    g = -1;
    pa = '0;
    pb = '0;
    if (!rst && model_credit < D)
      for (int k = 0; k < NR; k++)
        if (g < 0 && ((v >> ((model_rr + k) % NR)) & NR'(1)) != '0) g = (model_rr + k) % NR;
    if (g >= 0) begin
      exp_ready = NR'(1) << g;
      pa = PW'(W'(bus.req_a_i >> (g * W)));
      pb = PW'(W'(bus.req_b_i >> (g * W)));
    end
    chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
    if (|(bus.req_valid_i & bus.req_ready_o)) hs_cnt++;
    rsp_hs = bus.rsp_valid_o & bus.rsp_ready_i;
    if (rsp_hs) begin
      if (expq.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid_o), 64'(0));
      else begin
        e = expq.pop_front();
        chk("rsp_id", 64'(bus.rsp_id_o), 64'(e.id));
        chk("rsp_product", 64'(bus.rsp_product_o), 64'(e.p));
      end
    end
    @(posedge clk);
    if (rst) begin
      expq.delete();
      model_credit = 0;
      model_rr = 0;
    end else begin
      if (g >= 0) begin
        e.id = g;
        e.p  = pa * pb;
        expq.push_back(e);
        model_rr = (g + 1) % NR;
        model_credit++;
      end
      if (rsp_hs) model_credit--;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid_i = NR'(1) << id;
    bus.req_a_i = (NR*W)'(a) << (id * W);
    bus.req_b_i = (NR*W)'(b) << (id * W);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      bus.req_a_i[i*W +: W] = W'($urandom);
      bus.req_b_i[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = 1'b1;
    while (expq.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_empty", 64'(expq.size()), 64'(0));
  endtask

  task automatic single_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [PW-1:0] p);
    int lat = 0;
    set_req(id, a, b);
    bus.rsp_ready_i = 1'b1;
    cycle();
    bus.req_valid_i = '0;
    while (!bus.rsp_valid_o && lat < 20) begin
      cycle();
      lat++;
    end
    chk("latency", 64'(lat), 64'(L + 2));
    chk("single_id", 64'(bus.rsp_id_o), 64'(id));
    chk("single_product", 64'(bus.rsp_product_o), 64'(p));
    chk("single_err", 64'(bus.err_o), 64'(0));
    cycle();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mul_valid"}, 64'(bus.mul_valid_o), 64'(0));
    chk({tag, "_mul_a"}, 64'(bus.mul_a_o), 64'(0));
    chk({tag, "_mul_b"}, 64'(bus.mul_b_o), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(0));
    chk({tag, "_rsp_id"}, 64'(bus.rsp_id_o), 64'(0));
    chk({tag, "_rsp_product"}, 64'(bus.rsp_product_o), 64'(0));
    chk({tag, "_err"}, 64'(bus.err_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   seen;
    vecs[0] = '{2, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vecs[1] = '{0, 24'h000000, 24'h123456, 48'h0};
    vecs[2] = '{1, 24'h000001, 24'hABCDEF, 48'hABCDEF};
    vecs[3] = '{3, 24'h800000, 24'h000002, 48'h1000000};
    vecs[4] = '{2, 24'h000100, 24'h000100, 48'h10000};
    vecs[5] = '{3, 24'hFFFFFF, 24'h000001, 48'hFFFFFF};

    bus.req_valid_i = '0;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    chk_outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) single_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);

    // Round robin with every requester valid.
    do_reset();
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = '1;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      #1;
      chk("rr_grant", 64'(bus.req_ready_o), 64'(NR'(1) << (k % NR)));
      cycle();
    end
    drain(60);

    // Backpressure fills all credits, then the same-cycle release case.
    do_reset();
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = NR'(1);
    hs_cnt = 0;
    repeat (40) begin
      rand_ops();
      cycle();
    end
    chk("bp_accepted", 64'(hs_cnt), 64'(D));
    chk("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'(1));
    bus.rsp_ready_i = 1'b1;
    #1;
    chk("sim_ready_blocked", 64'(bus.req_ready_o), 64'(0));
    cycle();
    #1;
    chk("sim_ready_next", 64'(bus.req_ready_o), 64'(1));
    cycle();
    drain(80);
    chk("bp_err", 64'(bus.err_o), 64'(0));

    // Random traffic against the reference model.
    do_reset();
    repeat (300) begin
      bus.req_valid_i = NR'($urandom);
      rand_ops();
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(100);
    chk("rand_err", 64'(bus.err_o), 64'(0));

    // Product with no outstanding issue.
    do_reset();
    bus.rsp_ready_i = 1'b1;
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    seen = 0;
    repeat (12) begin
      cycle();
      if (bus.rsp_valid_o) seen++;
    end
    chk("mm_no_rsp", 64'(seen), 64'(0));
    chk("mm_err", 64'(bus.err_o), 64'(1));
    repeat (5) cycle();
    chk("mm_err_sticky", 64'(bus.err_o), 64'(1));
    do_reset();
    chk("mm_err_cleared", 64'(bus.err_o), 64'(0));

    // Reset with five operations in flight.
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = NR'(2);
    repeat (5) begin
      rand_ops();
      cycle();
    end
    bus.req_valid_i = '0;
    cycle();
    rst = 1'b1;
    cycle();
    chk_outputs_zero("midrst");
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      cycle();
      if (bus.rsp_valid_o) seen++;
    end
    chk("midrst_no_stale", 64'(seen), 64'(0));
    single_op(3, 24'h123456, 24'h000010, 48'h1234560);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Round-robin scheduler that shares one fixed-latency pipelined unsigned multiplier (e.g. the FP32 mantissa Karatsuba unit) between NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready and issues at most one per cycle into the multiplier.
- Tags each issue with its requester ID through a latency-matched tag pipe.
- Returns products, with ID, through a credit-protected result FIFO on one shared response channel with backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 24, operand width.
- MULT_LATENCY, 8, cycles from mul_valid_o high to matching mul_valid_i high (≥1).
- FIFO_DEPTH, 16, result FIFO entries; power of 2, ≥ MULT_LATENCY+2 for full throughput.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester operand valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  NUM_REQ*WIDTH  multiplicands; requester i at bits [i*WIDTH +: WIDTH].
- req_b_i  in  NUM_REQ*WIDTH  multipliers; same packing.
- mul_valid_o  out  1  issue strobe to multiplier.
- mul_a_o  out  WIDTH  multiplicand to multiplier.
- mul_b_o  out  WIDTH  multiplier operand to multiplier.
- mul_valid_i  in  1  product valid from multiplier.
- mul_product_i  in  2*WIDTH  product from multiplier.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_id_o  out  $clog2(NUM_REQ)  requester ID of response.
- rsp_product_o  out  2*WIDTH  product.
- err_o  out  1  sticky tag/valid mismatch or FIFO overflow.

Behaviour:
- Reset (rst_i high at a clock edge) clears all registers: mul_valid_o=0, mul_a_o=0, mul_b_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_product_o=0, err_o=0.
- Reset also clears tag pipe, FIFO pointers, credit counter and RR pointer; the RR pointer resets to requester 0 as highest priority.
- Reset mid-operation drops all in-flight work. The multiplier's own reset is driven from the same source, so nothing returns.
- While rst_i is high, req_ready_o=0.
- Credit: credit_cnt counts issued-but-not-yet-responded operations (in flight plus in FIFO).
  - can_issue = credit_cnt < FIFO_DEPTH.
  - +1 on issue, −1 on rsp handshake, unchanged when both occur in the same cycle.
- Arbitration (combinational):
  - Among requesters with req_valid_i set, grant the first at or after rr_ptr, scanning upward with wrap.
  - req_ready_o = grant when can_issue, else 0.
  - Handshake = req_valid_i[i] & req_ready_o[i].
  - On a handshake, rr_ptr <= granted index + 1 mod NUM_REQ. With no handshake, rr_ptr holds.
- Issue register: on a handshake at edge T, mul_valid_o=1 and mul_a_o/mul_b_o = the granted operands during cycle T+1.
  - With no handshake, mul_valid_o=0 and the operands hold their previous value.
- Tag pipe: shift register of MULT_LATENCY stages of {valid, id}, loaded from the issue register each cycle.
  - Its output is aligned with mul_valid_i.
- Return path:
  - On mul_valid_i=1 with tag-out valid: write {id, mul_product_i} into the FIFO.
  - mul_valid_i=1 with tag-out invalid: drop the product and set err_o.
  - Tag-out valid with mul_valid_i=0: drop the tag, set err_o and decrement credit_cnt.
- FIFO:
  - Registered output, no fall-through; rsp_* reflect the head entry.
  - Write into an empty FIFO at edge E gives rsp_valid_o=1 from cycle E+1.
  - Simultaneous read and write when full is legal. A write when full cannot occur under credits; if it does, drop it and set err_o.
  - rsp_* hold stable while rsp_valid_o=1 and rsp_ready_i=0.
- Latency: requester handshake at edge T → rsp_valid_o at T+MULT_LATENCY+2 when the FIFO is empty and unblocked.
- Throughput: 1 issue/cycle while credits are available.
- err_o clears only on reset.

Test Plan:
- Single op: requester 2 sends a=0xFFFFFF, b=0xFFFFFF; rsp_ready_i=1 → rsp_valid_o at T+10 (MULT_LATENCY=8), rsp_id_o=2, rsp_product_o=0xFFFFFE000001, err_o=0.
- Round-robin: all 4 requesters continuously valid → grants 0,1,2,3,0,1… one per cycle; responses in the same ID order, each product correct.
- Backpressure: rsp_ready_i=0, requester 0 streaming → exactly 16 issues accepted, then req_ready_o=0. Raising rsp_ready_i → all 16 drain in order, issuing resumes, no err_o.
- Simultaneous: credit_cnt=16 while a rsp handshake and a new request occur in the same cycle → request accepted only the next cycle, count stays ≤16.
- Mismatch: inject mul_valid_i=1 with no outstanding issue → err_o=1 sticky, no response emitted.
- Reset mid-stream: assert rst_i for 1 cycle with 5 ops in flight → all outputs 0 next cycle, no stale responses, a fresh op returns at T+10 with the correct ID.
